cobra_exec_ctrl: RTL and testbench
==================================

Name: cobra_exec_ctrl

Overview:
- Execution controller for the CYBERcobra core. Gates instruction retirement with a clock-enable and supports run, single-step, halt, PC breakpoint and an instruction-count watchdog.
- Takes raw board buttons plus the core's PC and out_o.
- Drives the core's clock-enable and synchronous reset.
- Exports state, retired-instruction count and a halt-time snapshot for the display/debug path.

Parameters:
- CYCLE_LIMIT, 0, watchdog limit on retired instructions; 0 disables the watchdog.
- SYNC_STAGES, 2, synchronizer flops per button input; minimum 2.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- run_i  in  1  raw run button, asynchronous.
- step_i  in  1  raw single-step button, asynchronous.
- halt_i  in  1  raw halt button, asynchronous.
- clear_i  in  1  raw restart button, asynchronous.
- bp_en_i  in  1  breakpoint enable, quasi-static.
- bp_addr_i  in  32  breakpoint PC, quasi-static.
- pc_i  in  32  core program counter.
- core_out_i  in  32  core out_o.
- core_en_o  out  1  core clock-enable; one instruction retires per high cycle.
- core_rst_o  out  1  core synchronous reset.
- state_o  out  2  current state encoding.
- instr_cnt_o  out  32  retired-instruction count.
- snap_o  out  32  core_out_i captured on entry to HALT.
- bp_hit_o  out  1  sticky flag: last halt was caused by the breakpoint.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, instr_cnt_o=0, snap_o=0, bp_hit_o=0, skip=0, all synchronizer flops=0.
  - core_rst_o=1 while in reset and for exactly one cycle after release (RSTHOLD flop), then 0.
  - core_en_o=0.
- Button path:
  - Each button is synchronized through SYNC_STAGES flops, then a previous-value flop.
  - pulse = sync_out & ~prev, high for exactly one cycle per rising edge.
  - Level held high gives no repeat pulse.
  - Latency: the state transition occurs on the (SYNC_STAGES+1)th rising edge after the input goes high.
- Pulse priority when simultaneous: clear > halt > step > run.
- States (enum): IDLE=0, RUN=1, STEP=2, HALT=3.
- IDLE:
  - run -> RUN; step -> STEP; halt -> HALT.
- RUN:
  - core_en_o = ~bp_match & ~limit_hit.
    - bp_match = bp_en_i & (pc_i==bp_addr_i) & ~skip.
    - limit_hit = (CYCLE_LIMIT!=0) & (instr_cnt_o>=CYCLE_LIMIT).
  - bp_match -> HALT with bp_hit_o=1; the matching instruction is not executed.
  - limit_hit -> HALT.
  - halt pulse -> HALT.
  - skip clears after the first core_en_o cycle.
- STEP:
  - core_en_o=1 for exactly one cycle, unless limit_hit; the breakpoint is ignored.
  - Next state HALT.
- HALT:
  - core_en_o=0.
  - run -> RUN and step -> STEP; both set skip=1 and clear bp_hit_o.
  - skip lets execution leave a breakpointed PC.
- snap_o:
  - Loaded with core_out_i on every transition into HALT, sampled in the cycle before entry.
  - Held otherwise.
- instr_cnt_o:
  - +1 on each cycle with core_en_o=1.
  - Saturates at 32'hFFFFFFFF; no wrap.
- clear pulse, from any state:
  - Next cycle: state=IDLE, core_rst_o=1 for exactly one cycle, instr_cnt_o=0, bp_hit_o=0, skip=0.
  - snap_o is kept.
  - core_en_o=0 during the core_rst_o cycle.
- core_en_o and core_rst_o are never both 1.
- state_o = state encoding, registered.
- Async reset mid-RUN: core_en_o drops immediately (combinational from the async-cleared state); core_rst_o asserts immediately.

Decomposition:
- Package cobra_ctrl_pkg:
  - state_t enum {IDLE, RUN, STEP, HALT} as logic [1:0].
  - Constant CNT_MAX = 32'hFFFFFFFF.
- Sub-module btn_edge_sync (parameter SYNC_STAGES; ports clk_i, rst_ni, btn_i, pulse_o), instantiated four times.
- The FSM, counter, snapshot and breakpoint logic live in cobra_exec_ctrl.

Test Plan:
- Reset then run: release rst_ni; check core_rst_o=1 for one cycle after release. Pulse run_i for 5 cycles; check run_i does not repeat. Check core_en_o rises on edge 3 after run_i and instr_cnt_o=10 after 10 enabled cycles.
- Breakpoint: bp_en_i=1, bp_addr_i=32'h10; pc_i steps 0,4,8,C,10. Check core_en_o=0 when pc_i=10, state_o=3, bp_hit_o=1, snap_o=core_out_i (32'hA5A5A5A5). Then a run pulse: one core_en_o cycle at pc 10, execution continues, bp_hit_o=0.
- Single-step from HALT: three step pulses; check exactly three single-cycle core_en_o pulses, instr_cnt_o +3, state_o=3 after each.
- Watchdog: CYCLE_LIMIT=8, run. Check exactly 8 core_en_o cycles, then state_o=3 and instr_cnt_o=8. A further run pulse gives no enable.
- Priority/clear: clear_i and run_i asserted in the same cycle while in RUN with instr_cnt_o=20. Check state_o=0, instr_cnt_o=0, one core_rst_o pulse, core_en_o=0.
- Async reset mid-RUN: drop rst_ni between clock edges. Check core_en_o=0 and core_rst_o=1 immediately, and all outputs at reset values before the next edge.

Source files
------------

// File: rtl/cobra_ctrl_pkg.sv
// Shared types and constants for the CYBERcobra execution controller.
package cobra_ctrl_pkg;

  // Controller states; the encoding is exported on state_o.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  // Saturation value of the retired-instruction counter.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Saturating increment: the counter sticks at CNT_MAX instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronizes one raw board button and turns each rising edge into a
// single-cycle pulse. SYNC_STAGES must be at least 2.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain followed by a previous-value flop for edge detection.
  // NOTE: non-blocking assignments so every flop samples its pre-edge input;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // High only in the first cycle the synchronized level is seen high.
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cobra_exec_ctrl.sv
// Execution controller for the CYBERcobra core: gates retirement with a
// clock-enable and provides run, single-step, halt, PC breakpoint, an
// instruction-count watchdog and a restart that resets the core.
module cobra_exec_ctrl
  import cobra_ctrl_pkg::*;
#(
  parameter logic [31:0] CYCLE_LIMIT = 32'd0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        step_i,
  input  logic        halt_i,
  input  logic        clear_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] core_out_i,
  output logic        core_en_o,
  output logic        core_rst_o,
  output logic [1:0]  state_o,
  output logic [31:0] instr_cnt_o,
  output logic [31:0] snap_o,
  output logic        bp_hit_o
);

  logic run_p, step_p, halt_p, clear_p;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(run_i),   .pulse_o(run_p));
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(step_i),  .pulse_o(step_p));
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_halt_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(halt_i),  .pulse_o(halt_p));
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(clear_i), .pulse_o(clear_p));

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        bp_hit_q, bp_hit_d;
  logic        skip_q, skip_d;     // lets execution leave a breakpointed PC
  logic        rsthold_q, rsthold_d;
  logic        bp_match, limit_hit, en;

  assign bp_match  = bp_en_i && (pc_i == bp_addr_i) && !skip_q;
  assign limit_hit = (CYCLE_LIMIT != 32'd0) && (cnt_q >= CYCLE_LIMIT);

  // Next-state, enable and bookkeeping logic; clear overrides everything.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    bp_hit_d  = bp_hit_q;
    skip_d    = skip_q;
    rsthold_d = 1'b0;
    en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (halt_p)      state_d = HALT;
        else if (step_p) state_d = STEP;
        else if (run_p)  state_d = RUN;
      end
      RUN: begin
        en = !bp_match && !limit_hit;
        if (halt_p || bp_match || limit_hit) state_d = HALT;
        if (bp_match) bp_hit_d = 1'b1;
      end
      STEP: begin
        en      = !limit_hit;
        state_d = HALT;
      end
      HALT: begin
        if (!halt_p && step_p) begin
          state_d  = STEP;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (!halt_p && run_p) begin
          state_d  = RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
    endcase

    if (en) begin
      cnt_d  = sat_inc(cnt_q);
      skip_d = 1'b0;
    end

    if (clear_p) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bp_hit_d  = 1'b0;
      skip_d    = 1'b0;
      rsthold_d = 1'b1;
    end

    if (state_d == HALT && state_q != HALT) snap_d = core_out_i;
  end

  // State and datapath registers; rsthold resets high so the core stays in
  // reset for one cycle after rst_ni releases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      bp_hit_q  <= 1'b0;
      skip_q    <= 1'b0;
      rsthold_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      bp_hit_q  <= bp_hit_d;
      skip_q    <= skip_d;
      rsthold_q <= rsthold_d;
    end
  end

  assign core_en_o   = en;
  assign core_rst_o  = rsthold_q;
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;
  assign snap_o      = snap_q;
  assign bp_hit_o    = bp_hit_q;

endmodule

// File: tb/tb_cobra_exec_ctrl.sv
// Directed bench for cobra_exec_ctrl. Expectations are queued before each
// stimulus phase and popped in order at the observation points. A second
// instance with a watchdog limit of 8 covers the limit behaviour.
module tb_cobra_exec_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst_n, run, step, halt, clear, bp_en;
  logic [31:0] bp_addr, pc, core_out;
  logic        core_en, core_rst, bp_hit;
  logic [1:0]  state;
  logic [31:0] cnt, snap;

  logic        wd_rst_n, wd_run;
  logic        wd_core_en, wd_core_rst, wd_bp_hit;
  logic [1:0]  wd_state;
  logic [31:0] wd_cnt, wd_snap;

  always #5 clk = ~clk;

  cobra_exec_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step), .halt_i(halt),
    .clear_i(clear), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .core_out_i(core_out), .core_en_o(core_en), .core_rst_o(core_rst),
    .state_o(state), .instr_cnt_o(cnt), .snap_o(snap), .bp_hit_o(bp_hit));

  cobra_exec_ctrl #(.CYCLE_LIMIT(32'd8)) dut_wd (
    .clk_i(clk), .rst_ni(wd_rst_n), .run_i(wd_run), .step_i(1'b0),
    .halt_i(1'b0), .clear_i(1'b0), .bp_en_i(1'b0), .bp_addr_i(32'h0),
    .pc_i(pc), .core_out_i(core_out), .core_en_o(wd_core_en),
    .core_rst_o(wd_core_rst), .state_o(wd_state), .instr_cnt_o(wd_cnt),
    .snap_o(wd_snap), .bp_hit_o(wd_bp_hit));

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: summary not reached");
    $fatal(1, "timeout");
  end

  initial begin
    int en_cnt;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0; clear = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0; core_out = 32'h0;
    wd_rst_n = 1'b0; wd_run = 1'b0;

    // Reset values
    cyc(2);
    expect_val("rst_state", 0); chk(32'(state));
    expect_val("rst_cnt", 0);   chk(cnt);
    expect_val("rst_snap", 0);  chk(snap);
    expect_val("rst_bp_hit", 0); chk(32'(bp_hit));
    expect_val("rst_core_rst", 1); chk(32'(core_rst));
    expect_val("rst_core_en", 0);  chk(32'(core_en));
    rst_n = 1'b1;
    #1;
    expect_val("rel_core_rst_hold", 1); chk(32'(core_rst));
    cyc(1);
    expect_val("rel_core_rst_drop", 0); chk(32'(core_rst));

    // Run: enable rises on the third edge after the press, held 5 cycles
    expect_val("run_en_edge2", 0);
    run = 1'b1;
    cyc(2); chk(32'(core_en));
    expect_val("run_en_edge3", 1);
    expect_val("run_state", 1);
    cyc(1); chk(32'(core_en)); chk(32'(state));
    cyc(2);
    run = 1'b0;
    cyc(8);
    expect_val("run_cnt10", 10); chk(cnt);

    // Breakpoint at PC 0x10
    bp_en = 1'b1; bp_addr = 32'h10; core_out = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      cyc(1);
    end
    pc = 32'h10;
    #1;
    expect_val("bp_en_blocked", 0); chk(32'(core_en));
    expect_val("bp_state", 3);
    expect_val("bp_hit", 1);
    expect_val("bp_snap", 32'hA5A5_A5A5);
    expect_val("bp_cnt", 14);
    expect_val("bp_en_halt", 0);
    cyc(1);
    chk(32'(state)); chk(32'(bp_hit)); chk(snap); chk(cnt); chk(32'(core_en));

    // Resume from the breakpoint: one enable at PC 0x10, then continue
    core_out = 32'h1111_0001;
    expect_val("res_state", 1);
    expect_val("res_en_at_bp", 1);
    expect_val("res_bp_hit_clr", 0);
    run = 1'b1;
    cyc(3); chk(32'(state)); chk(32'(core_en)); chk(32'(bp_hit));
    pc = 32'h14; run = 1'b0; halt = 1'b1;
    expect_val("res_cnt", 15);
    expect_val("res_continue_en", 1);
    cyc(1); chk(cnt); chk(32'(core_en));
    expect_val("halt_state", 3);
    expect_val("halt_cnt", 17);
    expect_val("halt_snap", 32'h1111_0001);
    expect_val("halt_bp_hit", 0);
    cyc(2); chk(32'(state)); chk(cnt); chk(snap); chk(32'(bp_hit));
    halt = 1'b0;

    // Three single steps, each button held for four cycles
    for (int k = 0; k < 3; k++) begin
      core_out = 32'h2222_0000 + 32'(k);
      expect_val("step_state", 2);
      expect_val("step_en", 1);
      step = 1'b1;
      cyc(3); chk(32'(state)); chk(32'(core_en));
      expect_val("step_halt_state", 3);
      expect_val("step_en_off", 0);
      expect_val("step_cnt", 32'(18 + k));
      expect_val("step_snap", 32'h2222_0000 + 32'(k));
      cyc(1); chk(32'(state)); chk(32'(core_en)); chk(cnt); chk(snap);
      step = 1'b0;
      expect_val("step_norepeat_cnt", 32'(18 + k));
      expect_val("step_norepeat_state", 3);
      cyc(2); chk(cnt); chk(32'(state));
    end

    // Clear and run pressed together while running: clear wins
    expect_val("pre_clr_state", 1);
    expect_val("pre_clr_cnt", 20);
    run = 1'b1;
    cyc(3); chk(32'(state)); chk(cnt);
    run = 1'b0;
    cyc(2);
    clear = 1'b1; run = 1'b1;
    expect_val("clr_state", 0);
    expect_val("clr_cnt", 0);
    expect_val("clr_core_rst", 1);
    expect_val("clr_core_en", 0);
    expect_val("clr_bp_hit", 0);
    expect_val("clr_snap_kept", 32'h2222_0002);
    cyc(3);
    chk(32'(state)); chk(cnt); chk(32'(core_rst)); chk(32'(core_en));
    chk(32'(bp_hit)); chk(snap);
    clear = 1'b0; run = 1'b0;
    expect_val("clr_core_rst_drop", 0);
    expect_val("clr_stay_idle", 0);
    expect_val("clr_en_idle", 0);
    cyc(1); chk(32'(core_rst)); chk(32'(state)); chk(32'(core_en));

    // Asynchronous reset in the middle of RUN
    run = 1'b1;
    cyc(3);
    run = 1'b0;
    cyc(2);
    expect_val("ar_pre_en", 1); chk(32'(core_en));
    #2 rst_n = 1'b0;
    #1;
    expect_val("ar_core_en", 0);  chk(32'(core_en));
    expect_val("ar_core_rst", 1); chk(32'(core_rst));
    expect_val("ar_state", 0);    chk(32'(state));
    expect_val("ar_cnt", 0);      chk(cnt);
    expect_val("ar_snap", 0);     chk(snap);
    expect_val("ar_bp_hit", 0);   chk(32'(bp_hit));
    cyc(1);
    rst_n = 1'b1;

    // Watchdog instance, limit 8
    wd_rst_n = 1'b1;
    expect_val("wd_core_rst_drop", 0);
    cyc(1); chk(32'(wd_core_rst));
    wd_run = 1'b1;
    expect_val("wd_run_state", 1);
    cyc(3); chk(32'(wd_state));
    wd_run = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (wd_core_en) en_cnt++;
      cyc(1);
    end
    expect_val("wd_en_cycles", 8); chk(32'(en_cnt));
    expect_val("wd_state_halt", 3); chk(32'(wd_state));
    expect_val("wd_cnt", 8); chk(wd_cnt);
    expect_val("wd_snap", 32'h2222_0002); chk(wd_snap);
    expect_val("wd_bp_hit", 0); chk(32'(wd_bp_hit));
    wd_run = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (wd_core_en) en_cnt++;
      cyc(1);
    end
    wd_run = 1'b0;
    expect_val("wd_rerun_en", 0); chk(32'(en_cnt));
    expect_val("wd_final_state", 3); chk(32'(wd_state));
    expect_val("wd_final_cnt", 8); chk(wd_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
